// File: rtl/pattern_buffer_mem.sv
// pattern_buffer_mem
// Pattern-field storage behind the PAT processor's field access port, with a
// host-side bank load/dump engine (valid/ready streams) that runs alongside
// the PAT.
//
// Ports:
//   clk, reset                    - rising-edge clock, async active-high reset
//   buf_fieldp / field_rdata      - PAT combinational read {bank, field}
//   buf_fieldwp / field_write_en /
//   field_wdata                   - PAT synchronous write {bank, field}
//   host_cmd_valid / host_cmd_write /
//   host_bank / host_cmd_ready    - host command (1 = load bank, 0 = dump bank)
//   host_abort                    - cancel the running load/dump
//   host_wdata / host_wvalid /
//   host_wready                   - load stream into the selected bank
//   host_rdata / host_rvalid /
//   host_rready                   - dump stream out of the selected bank
//   busy                          - engine is in LOAD or DUMP
//   done                          - one-cycle pulse when a command completes
module pattern_buffer_mem #(
  parameter int unsigned d_width      = 8,
  parameter int unsigned bufp_width   = 3,
  parameter int unsigned fieldp_width = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [bufp_width+fieldp_width-1:0] buf_fieldp,
  input  logic [bufp_width+fieldp_width-1:0] buf_fieldwp,
  input  logic                               field_write_en,
  input  logic [d_width-1:0]                 field_wdata,
  output logic [d_width-1:0]                 field_rdata,
  input  logic                               host_cmd_valid,
  input  logic                               host_cmd_write,
  input  logic [bufp_width-1:0]              host_bank,
  output logic                               host_cmd_ready,
  input  logic                               host_abort,
  input  logic [d_width-1:0]                 host_wdata,
  input  logic                               host_wvalid,
  output logic                               host_wready,
  output logic [d_width-1:0]                 host_rdata,
  output logic                               host_rvalid,
  input  logic                               host_rready,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned ADDR_W = bufp_width + fieldp_width;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [fieldp_width-1:0] LAST_IDX  = {fieldp_width{1'b1}};
  localparam logic [fieldp_width-1:0] FIRST_IDX = {fieldp_width{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [fieldp_width-1:0] idx_q;
  logic [bufp_width-1:0]   bank_q;
  logic [d_width-1:0]      mem [DEPTH];

  logic                    cmd_accept;
  logic                    load_beat;
  logic                    dump_beat;
  logic                    at_last;
  logic                    abort_active;
  logic [fieldp_width-1:0] idx_next;
  logic [ADDR_W-1:0]       load_addr;
  logic [ADDR_W-1:0]       dump_first_addr;
  logic [ADDR_W-1:0]       dump_next_addr;

  // Handshake strobes; abort masks any beat offered in the same cycle.
  always_comb begin
    cmd_accept      = (state_q == ST_IDLE) && host_cmd_valid;
    abort_active    = (state_q != ST_IDLE) && host_abort;
    load_beat       = (state_q == ST_LOAD) && host_wvalid && !host_abort;
    dump_beat       = (state_q == ST_DUMP) && host_rvalid && host_rready && !host_abort;
    at_last         = (idx_q == LAST_IDX);
    idx_next        = idx_q + fieldp_width'(1);
    load_addr       = {bank_q, idx_q};
    dump_first_addr = {host_bank, FIRST_IDX};
    dump_next_addr  = {bank_q, idx_next};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion is taken on the last index, never on overflow.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_cmd_valid) begin
          state_d = host_cmd_write ? ST_LOAD : ST_DUMP;
        end
      end
      ST_LOAD: begin
        if (host_abort) begin
          state_d = ST_IDLE;
        end else if (host_wvalid && at_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_DUMP: begin
        if (host_abort) begin
          state_d = ST_IDLE;
        end else if (host_rvalid && host_rready && at_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    host_cmd_ready = 1'b0;
    host_wready    = 1'b0;
    busy           = 1'b0;
    unique case (state_q)
      ST_IDLE: host_cmd_ready = 1'b1;
      ST_LOAD: begin
        host_wready = 1'b1;
        busy        = 1'b1;
      end
      ST_DUMP: busy = 1'b1;
      default: host_cmd_ready = 1'b1;
    endcase
  end

  // Engine datapath: index, latched bank, dump beat register and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      bank_q      <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (cmd_accept) begin
        bank_q <= host_bank;
        idx_q  <= '0;
        // Dump presents its first word one cycle after acceptance.
        if (!host_cmd_write) begin
          host_rdata  <= mem[dump_first_addr];
          host_rvalid <= 1'b1;
        end
      end

      if (load_beat) begin
        if (at_last) begin
          done <= 1'b1;
        end else begin
          idx_q <= idx_next;
        end
      end

      // Each beat is snapshotted at the edge it is fetched, so later PAT
      // writes cannot disturb a presented beat.
      if (dump_beat) begin
        if (at_last) begin
          host_rvalid <= 1'b0;
          done        <= 1'b1;
        end else begin
          idx_q      <= idx_next;
          host_rdata <= mem[dump_next_addr];
        end
      end

      if (abort_active) begin
        host_rvalid <= 1'b0;
      end
    end
  end

  // Storage; the PAT write is applied last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (load_beat) begin
        mem[load_addr] <= host_wdata;
      end
      if (field_write_en) begin
        mem[buf_fieldwp] <= field_wdata;
      end
    end
  end

  // PAT read is combinational; a same-cycle write shows up next cycle.
  assign field_rdata = mem[buf_fieldp];

endmodule

// File: tb/tb_pattern_buffer_mem.sv
// Bench for pattern_buffer_mem: directed scenarios plus randomized PAT/host
// traffic checked against a flat reference array of the storage.
module tb_pattern_buffer_mem;

  localparam int unsigned NF    = 32;
  localparam int unsigned DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buf_fieldp;
  logic [7:0] buf_fieldwp;
  logic       field_write_en;
  logic [7:0] field_wdata;
  logic [7:0] field_rdata;
  logic       host_cmd_valid;
  logic       host_cmd_write;
  logic [2:0] host_bank;
  logic       host_cmd_ready;
  logic       host_abort;
  logic [7:0] host_wdata;
  logic       host_wvalid;
  logic       host_wready;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       host_rready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [DEPTH];

  pattern_buffer_mem dut (
    .clk            (clk),
    .reset          (reset),
    .buf_fieldp     (buf_fieldp),
    .buf_fieldwp    (buf_fieldwp),
    .field_write_en (field_write_en),
    .field_wdata    (field_wdata),
    .field_rdata    (field_rdata),
    .host_cmd_valid (host_cmd_valid),
    .host_cmd_write (host_cmd_write),
    .host_bank      (host_bank),
    .host_cmd_ready (host_cmd_ready),
    .host_abort     (host_abort),
    .host_wdata     (host_wdata),
    .host_wvalid    (host_wvalid),
    .host_wready    (host_wready),
    .host_rdata     (host_rdata),
    .host_rvalid    (host_rvalid),
    .host_rready    (host_rready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and apply that edge's writes to the model (PAT last).
  task automatic edge_commit(input bit host_we, input logic [7:0] haddr, input logic [7:0] hdata);
    @(posedge clk);
    if (host_we) ref_mem[haddr] = hdata;
    if (field_write_en) ref_mem[buf_fieldwp] = field_wdata;
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input int bank);
    host_cmd_valid = 1'b1;
    host_cmd_write = wr;
    host_bank      = 3'(bank);
  endtask

  initial begin
    int b;
    int c;
    int rb;
    bit hw;
    bit first5;
    logic [7:0] exp_beat;

    reset = 1'b0; buf_fieldp = '0; buf_fieldwp = '0; field_write_en = 1'b0;
    field_wdata = '0; host_cmd_valid = 1'b0; host_cmd_write = 1'b0; host_bank = '0;
    host_abort = 1'b0; host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    // Reset and idle outputs
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_rd00", 32'(field_rdata), 32'h00);
    buf_fieldp = 8'hFF; #1;
    chk("rst_rdFF", 32'(field_rdata), 32'h00);
    chk("rst_cmd_ready", 32'(host_cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wready", 32'(host_wready), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'h00);
    chk("rst_done", 32'(done), 32'd0);

    // Read during write returns old value, new value next cycle
    buf_fieldp = 8'h2C; buf_fieldwp = 8'h2C; field_wdata = 8'hA5; field_write_en = 1'b1;
    #1 chk("rdw_old", 32'(field_rdata), 32'h00);
    edge_commit(1'b0, 8'h00, 8'h00);
    field_write_en = 1'b0;
    #1 chk("rdw_new", 32'(field_rdata), 32'hA5);

    // Random PAT writes and reads against the model
    for (int i = 0; i < 24; i++) begin
      buf_fieldwp = 8'($urandom); field_wdata = 8'($urandom); field_write_en = 1'b1;
      buf_fieldp = (i % 3 == 0) ? buf_fieldwp : 8'($urandom);
      #1 chk("pat_rand_rd", 32'(field_rdata), 32'(ref_mem[buf_fieldp]));
      edge_commit(1'b0, 8'h00, 8'h00);
    end
    field_write_en = 1'b0;

    // Load bank 3 with 0x00..0x1F at full rate
    issue_cmd(1'b1, 3);
    #1 chk("load3_cmd_ready", 32'(host_cmd_ready), 32'd1);
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0;
    for (int k = 0; k < NF; k++) begin
      host_wvalid = 1'b1; host_wdata = 8'(k);
      @(negedge clk);
      chk("load3_wready", 32'(host_wready), 32'd1);
      chk("load3_done_early", 32'(done), 32'd0);
      edge_commit(1'b1, 8'(3 * NF + k), 8'(k));
    end
    host_wvalid = 1'b0;
    @(negedge clk);
    chk("load3_done", 32'(done), 32'd1);
    chk("load3_idle", 32'(host_cmd_ready), 32'd1);
    chk("load3_busy", 32'(busy), 32'd0);
    edge_commit(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("load3_done_once", 32'(done), 32'd0);
    for (int a = 8'h60; a < 8'h80; a++) begin
      buf_fieldp = 8'(a); #1;
      chk("load3_rd", 32'(field_rdata), 32'(a - 8'h60));
    end

    // Dump bank 3 with rready toggling; PAT write lands while beat 5 is held
    issue_cmd(1'b0, 3);
    exp_beat = ref_mem[3 * NF];
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0;
    b = 0; c = 0; first5 = 1'b1;
    while (b < NF && c < 200) begin
      host_rready = (c % 2 == 0);
      if (b == 5 && first5) begin
        field_write_en = 1'b1; buf_fieldwp = 8'h65; field_wdata = 8'hEE; first5 = 1'b0;
      end else begin
        field_write_en = 1'b0;
      end
      @(negedge clk);
      chk("dump3_rvalid", 32'(host_rvalid), 32'd1);
      chk("dump3_beat", 32'(host_rdata), 32'(exp_beat));
      chk("dump3_done_early", 32'(done), 32'd0);
      if (host_rready) begin
        if (b < NF - 1) exp_beat = ref_mem[3 * NF + b + 1];
        b++;
      end
      edge_commit(1'b0, 8'h00, 8'h00);
      c++;
    end
    field_write_en = 1'b0; host_rready = 1'b0;
    chk("dump3_beats", 32'(b), 32'(NF));
    @(negedge clk);
    chk("dump3_rvalid_end", 32'(host_rvalid), 32'd0);
    chk("dump3_done", 32'(done), 32'd1);
    chk("dump3_idle", 32'(host_cmd_ready), 32'd1);
    edge_commit(1'b0, 8'h00, 8'h00);
    buf_fieldp = 8'h65; #1;
    chk("dump3_pat_write", 32'(field_rdata), 32'hEE);

    // Load bank 0 with a PAT write colliding on beat 4
    issue_cmd(1'b1, 0);
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0;
    for (int k = 0; k < NF; k++) begin
      host_wvalid = 1'b1; host_wdata = 8'(k);
      field_write_en = (k == 4); buf_fieldwp = 8'h04; field_wdata = 8'h77;
      @(negedge clk);
      chk("load0_done_early", 32'(done), 32'd0);
      edge_commit(1'b1, 8'(k), 8'(k));
    end
    host_wvalid = 1'b0; field_write_en = 1'b0;
    @(negedge clk);
    chk("load0_done", 32'(done), 32'd1);
    buf_fieldp = 8'h04; #1;
    chk("load0_collision", 32'(field_rdata), 32'h77);
    for (int a = 0; a < NF; a++) begin
      buf_fieldp = 8'(a); #1;
      chk("load0_rd", 32'(field_rdata), 32'(ref_mem[a]));
    end

    // Random load with stream gaps and random PAT writes (some colliding)
    rb = $urandom_range(0, 7);
    issue_cmd(1'b1, rb);
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0;
    b = 0; c = 0;
    while (b < NF && c < 400) begin
      host_wvalid = ($urandom_range(0, 3) != 0); host_wdata = 8'($urandom);
      field_write_en = ($urandom_range(0, 3) == 0);
      buf_fieldwp = ($urandom_range(0, 1) == 1) ? 8'(rb * NF + b) : 8'($urandom);
      field_wdata = 8'($urandom);
      hw = host_wvalid;
      edge_commit(hw, 8'(rb * NF + b), host_wdata);
      if (hw) b++;
      c++;
    end
    host_wvalid = 1'b0; field_write_en = 1'b0;
    chk("rload_beats", 32'(b), 32'(NF));
    @(negedge clk);
    chk("rload_done", 32'(done), 32'd1);
    chk("rload_busy", 32'(busy), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      buf_fieldp = 8'(a); #1;
      chk("rload_rd", 32'(field_rdata), 32'(ref_mem[a]));
    end

    // Random dump of that bank with random rready and PAT writes into the bank
    issue_cmd(1'b0, rb);
    exp_beat = ref_mem[rb * NF];
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0;
    b = 0; c = 0;
    while (b < NF && c < 400) begin
      host_rready = 1'($urandom_range(0, 1));
      field_write_en = ($urandom_range(0, 2) == 0);
      buf_fieldwp = 8'(rb * NF + $urandom_range(0, NF - 1)); field_wdata = 8'($urandom);
      @(negedge clk);
      chk("rdump_rvalid", 32'(host_rvalid), 32'd1);
      chk("rdump_beat", 32'(host_rdata), 32'(exp_beat));
      if (host_rready) begin
        if (b < NF - 1) exp_beat = ref_mem[rb * NF + b + 1];
        b++;
      end
      edge_commit(1'b0, 8'h00, 8'h00);
      c++;
    end
    host_rready = 1'b0; field_write_en = 1'b0;
    chk("rdump_beats", 32'(b), 32'(NF));
    @(negedge clk);
    chk("rdump_rvalid_end", 32'(host_rvalid), 32'd0);
    chk("rdump_done", 32'(done), 32'd1);

    // Abort a dump of bank 3 together with the 11th handshake
    edge_commit(1'b0, 8'h00, 8'h00);
    issue_cmd(1'b0, 3);
    exp_beat = ref_mem[3 * NF];
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0; host_rready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_beat", 32'(host_rdata), 32'(exp_beat));
      exp_beat = ref_mem[3 * NF + k + 1];
      edge_commit(1'b0, 8'h00, 8'h00);
    end
    host_abort = 1'b1;
    @(negedge clk);
    chk("abort_beat10", 32'(host_rdata), 32'(exp_beat));
    chk("abort_rvalid_pre", 32'(host_rvalid), 32'd1);
    edge_commit(1'b0, 8'h00, 8'h00);
    host_abort = 1'b0; host_rready = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 32'(host_rvalid), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(host_cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    edge_commit(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("abort_no_done_late", 32'(done), 32'd0);
    // Abort while idle is ignored
    host_abort = 1'b1;
    edge_commit(1'b0, 8'h00, 8'h00);
    host_abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ready", 32'(host_cmd_ready), 32'd1);
    chk("idle_abort_done", 32'(done), 32'd0);
    // A fresh dump restarts at field 0
    issue_cmd(1'b0, 3);
    edge_commit(1'b0, 8'h00, 8'h00);
    host_cmd_valid = 1'b0; host_rready = 1'b1;
    @(negedge clk);
    chk("restart_rvalid", 32'(host_rvalid), 32'd1);
    chk("restart_beat0", 32'(host_rdata), 32'(ref_mem[3 * NF]));
    edge_commit(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("restart_beat1", 32'(host_rdata), 32'(ref_mem[3 * NF + 1]));

    // Reset in the middle of the dump
    host_rready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    #1;
    chk("mrst_rvalid", 32'(host_rvalid), 32'd0);
    chk("mrst_rdata", 32'(host_rdata), 32'h00);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cmd_ready", 32'(host_cmd_ready), 32'd1);
    buf_fieldp = 8'h65; #1;
    chk("mrst_mem_clear", 32'(field_rdata), 32'(ref_mem[8'h65]));
    @(posedge clk);
    #1 reset = 1'b0;
    buf_fieldp = 8'h04; #1;
    chk("mrst_mem_clear2", 32'(field_rdata), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
